// File: rtl/pc_fetch_unit.sv
// PC register and fetch-redirect stage: advances the fetch address, applies EX-stage redirects,
// and parks a redirect that arrives during an instruction-memory miss until the miss clears.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        PC_MUX_OUT,
  input  logic [31:0] BRANCH_TARGET,
  input  logic        STALL,
  input  logic        IMEM_BUSYWAIT,
  output logic [31:0] PC,
  output logic [31:0] PC_PLUS_4,
  output logic        IMEM_READ,
  output logic        FLUSH,
  output logic [31:0] BRANCH_COUNT
);

  typedef enum logic [0:0] {StRun, StPending} state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] redir_pc_q;
  logic        imem_read_q;
  logic [31:0] branch_count_q;
  logic [31:0] eff_target;

  // Low address bits are dropped silently; misaligned targets raise no exception here.
  assign eff_target   = BRANCH_TARGET & 32'hFFFF_FFFC;
  assign PC           = pc_q;
  assign PC_PLUS_4    = pc_q + 32'd4;
  assign IMEM_READ    = imem_read_q;
  assign BRANCH_COUNT = branch_count_q;

  // The first edge after reset release only starts fetching, so no redirect is taken there.
  assign FLUSH = RESET & imem_read_q & ((state_q == StPending) | PC_MUX_OUT);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q        <= StRun;
      pc_q           <= RESET_PC;
      redir_pc_q     <= 32'h0;
      imem_read_q    <= 1'b0;
      branch_count_q <= 32'h0;
    end else if (!imem_read_q) begin
      imem_read_q <= 1'b1;
    end else begin
      unique case (state_q)
        StRun: begin
          if (PC_MUX_OUT) begin
            branch_count_q <= branch_count_q + 32'd1;
            if (IMEM_BUSYWAIT) begin
              redir_pc_q <= eff_target;
              state_q    <= StPending;
            end else begin
              pc_q <= eff_target;
            end
          end else if (!IMEM_BUSYWAIT && !STALL) begin
            pc_q <= pc_q + 32'd4;
          end
        end
        StPending: begin
          // STALL is deliberately ignored: the stalled instruction is being flushed anyway.
          if (!IMEM_BUSYWAIT) begin
            pc_q    <= redir_pc_q;
            state_q <= StRun;
          end
        end
        default: state_q <= StRun;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed scenarios followed by random stimulus,
// compared against a cycle-level behavioural model of the fetch rules.
module tb_pc_fetch_unit;

  localparam logic [31:0] ResetPc = 32'h0000_0000;

  logic        CLK;
  logic        RESET;
  logic        PC_MUX_OUT;
  logic [31:0] BRANCH_TARGET;
  logic        STALL;
  logic        IMEM_BUSYWAIT;
  logic [31:0] PC;
  logic [31:0] PC_PLUS_4;
  logic        IMEM_READ;
  logic        FLUSH;
  logic [31:0] BRANCH_COUNT;

  pc_fetch_unit #(.RESET_PC(ResetPc)) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .PC_MUX_OUT   (PC_MUX_OUT),
    .BRANCH_TARGET(BRANCH_TARGET),
    .STALL        (STALL),
    .IMEM_BUSYWAIT(IMEM_BUSYWAIT),
    .PC           (PC),
    .PC_PLUS_4    (PC_PLUS_4),
    .IMEM_READ    (IMEM_READ),
    .FLUSH        (FLUSH),
    .BRANCH_COUNT (BRANCH_COUNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_bad    = 0;

  // Reference model state
  logic [31:0] m_pc;
  logic [31:0] m_redir;
  logic [31:0] m_count;
  bit          m_pending;
  bit          m_started;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc      = ResetPc;
    m_redir   = 32'h0;
    m_count   = 32'h0;
    m_pending = 1'b0;
    m_started = 1'b0;
  endtask

  task automatic check_regs(input string tag);
    check({tag, ".pc"}, PC, m_pc);
    check({tag, ".imem_read"}, {31'h0, IMEM_READ}, {31'h0, m_started});
    check({tag, ".count"}, BRANCH_COUNT, m_count);
  endtask

  // Called just after a negedge: drive inputs, check combinational outputs, take one edge.
  task automatic step(input bit mux, input logic [31:0] tgt, input bit stall, input bit busy);
    PC_MUX_OUT    = mux;
    BRANCH_TARGET = tgt;
    STALL         = stall;
    IMEM_BUSYWAIT = busy;
    #1;
    check("flush", {31'h0, FLUSH}, {31'h0, m_started && (m_pending || mux)});
    check("pc_plus_4", PC_PLUS_4, m_pc + 32'd4);
    @(posedge CLK);
    if (!m_started) begin
      m_started = 1'b1;
    end else if (m_pending) begin
      if (!busy) begin
        m_pc      = m_redir;
        m_pending = 1'b0;
      end
    end else if (mux) begin
      m_count = m_count + 32'd1;
      if (busy) begin
        m_redir   = {tgt[31:2], 2'b00};
        m_pending = 1'b1;
      end else begin
        m_pc = {tgt[31:2], 2'b00};
      end
    end else if (!busy && !stall) begin
      m_pc = m_pc + 32'd4;
    end
    #1;
    check_regs("step");
    @(negedge CLK);
  endtask

  // Asynchronous reset pulse placed mid-cycle, away from both clock edges.
  task automatic async_reset();
    #2;
    RESET = 1'b0;
    model_reset();
    #1;
    check_regs("rst");
    check("rst.flush", {31'h0, FLUSH}, 32'h0);
    check("rst.pc_plus_4", PC_PLUS_4, ResetPc + 32'd4);
    @(negedge CLK);
    RESET = 1'b1;
  endtask

  initial begin
    RESET         = 1'b0;
    PC_MUX_OUT    = 1'b0;
    BRANCH_TARGET = 32'h0;
    STALL         = 1'b0;
    IMEM_BUSYWAIT = 1'b0;
    model_reset();
    @(negedge CLK);
    @(negedge CLK);
    check_regs("init");
    check("init.flush", {31'h0, FLUSH}, 32'h0);
    RESET = 1'b1;

    // Reset release and free-running advance up to 0x20
    for (int i = 0; i < 9; i++) step(0, 32'h0, 0, 0);
    check("advance_to_20", PC, 32'h20);

    // Taken branch with memory ready; low bits of target dropped
    step(1, 32'h103, 0, 0);
    check("branch_ready", PC, 32'h100);

    // Branch during a miss, parked until busywait drops
    step(1, 32'h200, 0, 1);
    for (int i = 0; i < 3; i++) step(1, 32'h999, 0, 1);
    step(0, 32'h0, 1, 0);
    check("branch_miss", PC, 32'h200);
    check("branch_miss.count", BRANCH_COUNT, 32'd2);

    // Redirect wins over stall
    step(0, 32'h0, 1, 0);
    step(1, 32'h40, 1, 0);
    step(0, 32'h0, 1, 0);
    check("stall_redirect", PC, 32'h40);

    // Address wrap
    step(1, 32'hFFFF_FFFE, 0, 0);
    step(0, 32'h0, 0, 0);
    check("pc_wrap", PC, 32'h0);

    // Reset while a redirect is pending; 0x300 must never appear
    step(1, 32'h300, 0, 1);
    step(0, 32'h0, 0, 1);
    async_reset();
    for (int i = 0; i < 6; i++) step(0, 32'h0, 0, 0);

    // Random traffic with occasional asynchronous resets
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        async_reset();
      end else begin
        step(m_started && ($urandom_range(0, 5) == 0), $urandom,
             $urandom_range(0, 4) == 0, $urandom_range(0, 2) == 0);
      end
    end

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
